// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional `IDEX_PERF_EN adds saturating bubble_cnt / flush_cnt outputs.
module id_ex_latch #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             pipe_en,
    input  logic             flush,
    input  logic [31:0]      instr_ID,
    input  logic [31:0]      pc4_ID,
    input  logic [31:0]      busA_ID,
    input  logic [31:0]      busB_ID,
    input  logic [31:0]      imm_ID,
    input  logic [3:0]       aluop_ID,
    input  logic             ALUSrc_ID,
    input  logic             RegWr_ID,
    input  logic             memWr_ID,
    input  logic             memtoReg_ID,
    input  logic             halt_ID,
    output logic [31:0]      instr_EX,
    output logic [31:0]      pc4_EX,
    output logic [31:0]      busA_EX,
    output logic [31:0]      busB_EX,
    output logic [31:0]      imm_EX,
    output logic [3:0]       aluop_EX,
    output logic             ALUSrc_EX,
    output logic             RegWr_EX,
    output logic             memWr_EX,
    output logic             memtoReg_EX,
    output logic             halt_EX,
    output logic             valid_EX,
    output logic             luse_stall
`ifdef IDEX_PERF_EN
    ,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;

    logic [31:0] r_instr, r_pc4, r_busA, r_busB, r_imm;
    logic [3:0]  r_aluop;
    logic        r_aluSrc, r_regWr, r_memWr, r_memtoReg, r_halt, r_valid;

    logic [5:0]  w_idOp;
    logic [4:0]  w_idRs, w_idRt, w_exRt;
    logic        w_idUsesRt, w_hz;

    assign w_idOp = instr_ID[31:26];
    assign w_idRs = instr_ID[25:21];
    assign w_idRt = instr_ID[20:16];
    assign w_exRt = r_instr[20:16];

    // Only these ID opcodes actually read rt as a source; for the rest rt is a destination.
    assign w_idUsesRt = (w_idOp == OP_RTYPE) || (w_idOp == OP_SW) ||
                        (w_idOp == OP_BEQ)   || (w_idOp == OP_BNE);

    assign w_hz = r_valid && r_memtoReg && (w_exRt != 5'd0) &&
                  ((w_idRs == w_exRt) || (w_idUsesRt && (w_idRt == w_exRt)));

    assign luse_stall = w_hz && !flush;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_instr    <= NOP_WORD;
            r_pc4      <= '0;
            r_busA     <= '0;
            r_busB     <= '0;
            r_imm      <= '0;
            r_aluop    <= '0;
            r_aluSrc   <= 1'b0;
            r_regWr    <= 1'b0;
            r_memWr    <= 1'b0;
            r_memtoReg <= 1'b0;
            r_halt     <= 1'b0;
            r_valid    <= 1'b0;
        end else if (pipe_en) begin
            if (flush || w_hz) begin
                r_instr    <= NOP_WORD;
                r_pc4      <= '0;
                r_busA     <= '0;
                r_busB     <= '0;
                r_imm      <= '0;
                r_aluop    <= '0;
                r_aluSrc   <= 1'b0;
                r_regWr    <= 1'b0;
                r_memWr    <= 1'b0;
                r_memtoReg <= 1'b0;
                r_halt     <= 1'b0;
                r_valid    <= 1'b0;
            end else begin
                r_instr    <= instr_ID;
                r_pc4      <= pc4_ID;
                r_busA     <= busA_ID;
                r_busB     <= busB_ID;
                r_imm      <= imm_ID;
                r_aluop    <= aluop_ID;
                r_aluSrc   <= ALUSrc_ID;
                r_regWr    <= RegWr_ID;
                r_memWr    <= memWr_ID;
                r_memtoReg <= memtoReg_ID;
                r_halt     <= halt_ID;
                r_valid    <= 1'b1;
            end
        end
    end

    assign instr_EX    = r_instr;
    assign pc4_EX      = r_pc4;
    assign busA_EX     = r_busA;
    assign busB_EX     = r_busB;
    assign imm_EX      = r_imm;
    assign aluop_EX    = r_aluop;
    assign ALUSrc_EX   = r_aluSrc;
    assign RegWr_EX    = r_regWr;
    assign memWr_EX    = r_memWr;
    assign memtoReg_EX = r_memtoReg;
    assign halt_EX     = r_halt;
    assign valid_EX    = r_valid;

`ifdef IDEX_PERF_EN
    logic [CNT_W-1:0] r_bubbleCnt, r_flushCnt;

    // A flush bubble is counted as a flush even when a hazard is also present.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_bubbleCnt <= '0;
            r_flushCnt  <= '0;
        end else if (pipe_en) begin
            if (flush) begin
                if (r_flushCnt != '1) r_flushCnt <= r_flushCnt + CNT_W'(1);
            end else if (w_hz) begin
                if (r_bubbleCnt != '1) r_bubbleCnt <= r_bubbleCnt + CNT_W'(1);
            end
        end
    end

    assign bubble_cnt = r_bubbleCnt;
    assign flush_cnt  = r_flushCnt;
`endif

endmodule
